// File: rtl/maj_tt_pkg.sv
// maj_tt_pkg: shared types, operand-select codes and operand picker for maj_tt_scheduler
package maj_tt_pkg;
  localparam logic [3:0] SEL_X0 = 4'd0;
  localparam logic [3:0] SEL_X1 = 4'd1;
  localparam logic [3:0] SEL_X2 = 4'd2;
  localparam logic [3:0] SEL_X3 = 4'd3;
  localparam logic [3:0] SEL_X4 = 4'd4;
  localparam logic [3:0] SEL_X5 = 4'd5;
  localparam logic [3:0] SEL_X6 = 4'd6;
  localparam logic [3:0] SEL_ZERO = 4'd7;
  localparam logic [3:0] SEL_NODE_BASE = 4'd8;

  typedef struct packed {
    logic inv_c;
    logic inv_b;
    logic inv_a;
    logic [3:0] sel_c;
    logic [3:0] sel_b;
    logic [3:0] sel_a;
  } cfg_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  // Node references at or beyond the node being evaluated read 0, so stale
  // register contents from the previous minterm can never leak in.
  function automatic logic pick(input logic [3:0] s, input logic [7:0] x,
                                input logic [7:0] nodes, input logic [2:0] idx);
    return (s >= SEL_NODE_BASE) ? (s[2:0] < idx && nodes[s[2:0]])
                                : (s != SEL_ZERO && x[s[2:0]]);
  endfunction
endpackage

// File: rtl/maj3_node.sv
// maj3_node: combinational three-input majority with per-operand inversion
module maj3_node (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);
  logic ai, bi, ci;
  assign ai = a ^ inv_a;
  assign bi = b ^ inv_b;
  assign ci = c ^ inv_c;
  assign y = (ai & bi) | (ai & ci) | (bi & ci);
endmodule

// File: rtl/maj_tt_scheduler.sv
// maj_tt_scheduler: enumerates 128 minterms through a shared MAJ3 to build a truth table (optional compare: MAJ_TT_COMPARE_EN)
module maj_tt_scheduler
  import maj_tt_pkg::*;
#(
  parameter int NODES = 6,
  parameter int MINTERMS = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [14:0] cfg_data,
  input  logic [3:0] num_nodes,
  input  logic start,
`ifdef MAJ_TT_COMPARE_EN
  input  logic [127:0] expect_tt,
  output logic match,
`endif
  output logic busy,
  output logic done,
  output logic [127:0] tt,
  output logic tt_valid
);
  state_t state, state_nxt;
  cfg_t cfg_q [NODES];
  cfg_t cur;
  logic [NODES-1:0] node_q;
  logic [7:0] nodes8;
  logic [6:0] m;
  logic [2:0] n;
  logic [3:0] nn, n_eff;
  logic a, b, c, y, last_n, last, accept;
  logic [127:0] tt_fin;

  assign cur = cfg_q[n];
  assign nodes8 = 8'(node_q);
  assign a = pick(cur.sel_a, {1'b0, m}, nodes8, n);
  assign b = pick(cur.sel_b, {1'b0, m}, nodes8, n);
  assign c = pick(cur.sel_c, {1'b0, m}, nodes8, n);
  assign last_n = (n == 3'(nn - 4'd1));
  assign last = last_n && (m == 7'(MINTERMS - 1));
  assign accept = (state == IDLE) && start;
  assign n_eff = (num_nodes == 4'd0) ? 4'd1 : (32'(num_nodes) > NODES) ? 4'(NODES) : num_nodes;
  assign tt_fin = tt | (128'(y) << m);

  maj3_node u_maj (
    .a(a), .b(b), .c(c),
    .inv_a(cur.inv_a), .inv_b(cur.inv_b), .inv_c(cur.inv_c),
    .y(y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy = (state == EVAL);
    done = (state == DONE);
    state_nxt = (state == IDLE) ? (start ? EVAL : IDLE)
              : (state == EVAL) ? (last ? DONE : EVAL) : IDLE;
  end

  // Config file, counters, node registers and truth table
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) cfg_q[i] <= '0;
      node_q <= '0;
      m <= '0;
      n <= '0;
      nn <= '0;
      tt <= '0;
      tt_valid <= 1'b0;
    end else begin
      if (state == IDLE && cfg_we && 32'(cfg_addr) < NODES) cfg_q[cfg_addr] <= cfg_t'(cfg_data);
      if (accept) begin
        nn <= n_eff;
        m <= '0;
        n <= '0;
        node_q <= '0;
        tt <= '0;
        tt_valid <= 1'b0;
      end else if (state == EVAL) begin
        node_q[n] <= y;
        if (last_n) begin
          tt[m] <= y;
          n <= '0;
          m <= m + 7'd1;
        end else begin
          n <= n + 3'd1;
        end
        if (last) tt_valid <= 1'b1;
      end
    end
  end

`ifdef MAJ_TT_COMPARE_EN
  logic [127:0] exp_q;

  // Expected table captured at start, verdict registered alongside done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
      match <= 1'b0;
    end else if (accept) begin
      exp_q <= expect_tt;
      match <= 1'b0;
    end else if (state == EVAL && last) begin
      match <= (tt_fin == exp_q);
    end
  end
`endif
endmodule

// File: tb/tb_maj_tt_scheduler.sv
// tb_maj_tt_scheduler: scoreboard bench with a minterm-level reference model
module tb_maj_tt_scheduler;
  localparam int NODES = 6;
  localparam logic [127:0] SIX_TT = 128'hfeeafce8fce8e8c0fce8e8c0e8c0a880;
  localparam logic [127:0] X0_TT = {32{4'hA}};
  localparam logic [127:0] MAJ012_TT = {16{8'hE8}};

  logic clk = 0, rst_n = 0, cfg_we = 0, start = 0;
  logic [2:0] cfg_addr = 0;
  logic [14:0] cfg_data = 0;
  logic [3:0] num_nodes = 0;
  logic busy, done, tt_valid;
  logic [127:0] tt;
`ifdef MAJ_TT_COMPARE_EN
  logic [127:0] expect_tt = 0;
  logic match;
`endif

  always #5 clk = ~clk;

  maj_tt_scheduler #(.NODES(NODES), .MINTERMS(128)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_nodes(num_nodes), .start(start),
`ifdef MAJ_TT_COMPARE_EN
    .expect_tt(expect_tt), .match(match),
`endif
    .busy(busy), .done(done), .tt(tt), .tt_valid(tt_valid)
  );

  typedef struct {
    logic [127:0] tt;
    int lat;
    bit cm;
    bit em;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  bit want_cm = 0, want_em = 0;
  logic [14:0] mirror [NODES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [14:0] enc(int a, int b, int c, bit ia = 0, bit ib = 0, bit ic = 0);
    return {ic, ib, ia, 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic int neff(int nn);
    return nn == 0 ? 1 : (nn > NODES ? NODES : nn);
  endfunction

  // Evaluate the network minterm by minterm straight from the select rules
  function automatic logic [127:0] model(int nn);
    logic [127:0] r = '0;
    int cnt = neff(nn);
    for (int mt = 0; mt < 128; mt++) begin
      bit v[8];
      for (int i = 0; i < cnt; i++) begin
        int votes = 0;
        for (int j = 0; j < 3; j++) begin
          int s = int'((mirror[i] >> (4 * j)) & 15'hF);
          bit o;
          if (s < 7) o = bit'((mt >> s) & 1);
          else if (s == 7) o = 0;
          else o = (s - 8 < i) ? v[s - 8] : 1'b0;
          o = o ^ mirror[i][12 + j];
          votes += int'(o);
        end
        v[i] = votes >= 2;
      end
      r[mt] = v[cnt - 1];
    end
    return r;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", 128'(done), 128'(0));
      else begin
        e = sb.pop_front();
        chk("tt", tt, e.tt);
        chk("tt_valid_at_done", 128'(tt_valid), 128'(1));
        chk("latency", 128'(cyc - t0), 128'(e.lat));
`ifdef MAJ_TT_COMPARE_EN
        if (e.cm) chk("match", 128'(match), 128'(e.em));
`endif
      end
    end
  end

  task automatic wr(int a, logic [14:0] d);
    @(negedge clk);
    cfg_we = 1;
    cfg_addr = 3'(a);
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 0;
    if (a < NODES) mirror[a] = d;
  endtask

  task automatic go(int nn, logic [127:0] want, bit use_model, bit co = 0, int ca = 0, logic [14:0] cd = 0);
    exp_t e;
    @(negedge clk);
    num_nodes = 4'(nn);
    start = 1;
    if (co) begin
      cfg_we = 1;
      cfg_addr = 3'(ca);
      cfg_data = cd;
      if (ca < NODES) mirror[ca] = cd;
    end
    e.tt = use_model ? model(nn) : want;
    e.lat = 128 * neff(nn);
    e.cm = want_cm;
    e.em = want_em;
    sb.push_back(e);
    @(posedge clk);
    #1 t0 = cyc;
    start = 0;
    cfg_we = 0;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 1100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      chk("done_timeout", 128'(done), 128'(1));
      sb.delete();
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 128'(done), 128'(0));
      chk("tt_valid_hold", 128'(tt_valid), 128'(1));
      chk("busy_idle", 128'(busy), 128'(0));
    end
  endtask

  task automatic load_six();
    wr(0, enc(1, 2, 3));
    wr(1, enc(0, 1, 2));
    wr(2, enc(0, 6, 9));
    wr(3, enc(6, 8, 9));
    wr(4, enc(4, 5, 11));
    wr(5, enc(8, 10, 12));
  endtask

  initial begin
    for (int i = 0; i < NODES; i++) mirror[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tt", tt, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_tt_valid", 128'(tt_valid), 128'(0));
`ifdef MAJ_TT_COMPARE_EN
    chk("rst_match", 128'(match), 128'(0));
`endif
    rst_n = 1;

    wr(0, enc(0, 1, 2));
    go(1, MAJ012_TT, 0);
    wait_done();

    wr(0, enc(0, 7, 7, 0, 1, 0));
    go(1, X0_TT, 0);
    wait_done();
    @(negedge clk);
    chk("tt_valid_idle_hold", 128'(tt_valid), 128'(1));

    wr(0, enc(9, 0, 0));
    go(1, X0_TT, 0);
    wait_done();

    load_six();
    go(6, SIX_TT, 0);
    wait_done();

    go(6, SIX_TT, 0);
    repeat (100) @(negedge clk);
    start = 1;
    cfg_we = 1;
    cfg_addr = 0;
    cfg_data = enc(7, 7, 7);
    num_nodes = 1;
    @(negedge clk);
    start = 0;
    cfg_we = 0;
    wait_done();

    wr(6, 15'h7fff);
    go(6, SIX_TT, 0);
    wait_done();

`ifdef MAJ_TT_COMPARE_EN
    want_cm = 1;
    want_em = 1;
    expect_tt = SIX_TT;
    go(6, SIX_TT, 0);
    wait_done();
    want_em = 0;
    expect_tt = SIX_TT ^ 128'd1;
    go(6, SIX_TT, 0);
    wait_done();
    want_cm = 0;
`endif

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 4; w++) wr(int'($urandom_range(0, 7)), 15'($urandom));
      go(int'($urandom_range(0, 15)), '0, 1, r[0], int'($urandom_range(0, 7)), 15'($urandom));
      wait_done();
    end

    go(6, '0, 1);
    repeat (200) @(negedge clk);
    rst_n = 0;
    sb.delete();
    for (int i = 0; i < NODES; i++) mirror[i] = '0;
    repeat (2) @(negedge clk);
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_tt", tt, 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_tt_valid", 128'(tt_valid), 128'(0));
    rst_n = 1;
    repeat (800) @(negedge clk);
    go(6, X0_TT, 0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
